// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and constants for initiators on the native
//               32-bit memory bus (state encoding, strobe values, word size).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  // Copy engine states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR     = 3'd3,
    ST_WR_GAP = 3'd4,
    ST_FIN    = 3'd5
  } copy_state_t;

  localparam logic [3:0]  WSTRB_READ = 4'h0;
  localparam logic [3:0]  WSTRB_WORD = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Clear the byte-offset bits so the address points at a whole word
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_copy_master_bus_timeout.sv
// ============================================================================
// Module      : bus_timeout
// Description : Wait-cycle counter for a bus initiator. Counts cycles spent
//               waiting for ready and flags the cycle on which the wait
//               reaches TIMEOUT cycles. Shared with the CPU-side watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_timeout #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int c_cnt_w = $clog2(TIMEOUT + 1);

  logic [c_cnt_w-1:0] r_count;

  // Count waiting cycles; clear whenever the owner is not on the bus
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

  // Asserted during the TIMEOUT-th waiting cycle so the owner can abort at its end
  assign expired = tick && !clr && (r_count == c_cnt_w'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_copy_master.sv
// ============================================================================
// Module      : mem_copy_master
// Description : Word-copy initiator on the native memory bus. Reads len words
//               from src and writes them to dst, one read/write pair at a
//               time with an idle gap after each transfer so the repeated
//               ready of a registered-ready responder is never mistaken for
//               a new acknowledge. Aborts with error on a bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_master #(
  parameter int TIMEOUT = 256,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata
);

  import mem_bus_pkg::*;

  copy_state_t      r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_words_done;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic             r_mem_valid;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wstrb;

  logic             w_on_bus;
  logic             w_tmo_clr;
  logic             w_tmo_tick;
  logic             w_expired;

  // The wait counter only runs while a request is outstanding
  assign w_on_bus   = (r_state == ST_RD) || (r_state == ST_WR);
  assign w_tmo_clr  = !w_on_bus;
  assign w_tmo_tick = w_on_bus && !mem_ready;

  bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (w_tmo_clr),
    .tick    (w_tmo_tick),
    .expired (w_expired)
  );

  // Copy sequencer with its address/count datapath and registered bus outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= WSTRB_READ;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_error      <= 1'b0;
            r_words_done <= '0;
            r_busy       <= 1'b1;
            if (len != '0) begin
              r_src       <= word_align(src);
              r_dst       <= word_align(dst);
              r_remaining <= len;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= word_align(src);
              r_mem_wstrb <= WSTRB_READ;
              r_state     <= ST_RD;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end
          end
        end

        ST_RD: begin
          if (w_expired) begin
            r_mem_valid <= 1'b0;
            r_error     <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= ST_FIN;
          end else if (mem_ready) begin
            r_mem_wdata <= mem_rdata;
            r_mem_valid <= 1'b0;
            r_state     <= ST_RD_GAP;
          end
        end

        ST_RD_GAP: begin
          r_mem_valid <= 1'b1;
          r_mem_addr  <= r_dst;
          r_mem_wstrb <= WSTRB_WORD;
          r_state     <= ST_WR;
        end

        ST_WR: begin
          if (w_expired) begin
            r_mem_valid <= 1'b0;
            r_error     <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= ST_FIN;
          end else if (mem_ready) begin
            r_words_done <= r_words_done + LEN_W'(1);
            r_src        <= r_src + WORD_BYTES;
            r_dst        <= r_dst + WORD_BYTES;
            r_remaining  <= r_remaining - LEN_W'(1);
            r_mem_valid  <= 1'b0;
            r_state      <= ST_WR_GAP;
          end
        end

        ST_WR_GAP: begin
          if (r_remaining == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= r_src;
            r_mem_wstrb <= WSTRB_READ;
            r_state     <= ST_RD;
          end
        end

        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_mem_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign words_done = r_words_done;
  assign mem_valid  = r_mem_valid;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_master.sv
// ============================================================================
// Module      : tb_mem_copy_master
// Description : Self-checking bench for mem_copy_master with a registered-ready
//               responder (per-direction wait states, repeated ready after
//               valid falls) and a transaction-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_master;

  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 8;

  logic             clk   = 1'b0;
  logic             rstn  = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src   = '0;
  logic [31:0]      dst   = '0;
  logic [LEN_W-1:0] len   = '0;
  logic             busy, done, error, mem_valid;
  logic [LEN_W-1:0] words_done;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_ready = 1'b0;
  logic [31:0]      mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_copy_master #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- responder: source memory, registered ready ----------------
  logic [31:0] mem [logic [31:0]];
  int unsigned rd_waits = 0, wr_waits = 0;
  bit          no_ready = 1'b0;
  int unsigned rsp_cnt  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_5A5A;
  endfunction

  always @(posedge clk) begin
    if (mem_valid && !no_ready) begin
      mem_ready <= (rsp_cnt >= ((mem_wstrb == 4'h0) ? rd_waits : wr_waits));
      rsp_cnt   <= rsp_cnt + 1;
      if (mem_wstrb == 4'h0) mem_rdata <= mem_word(mem_addr);
    end else begin
      mem_ready <= 1'b0;
      rsp_cnt   <= 0;
    end
  end

  // ---------------- monitor: accepted transactions and bus rules ----------------
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  int unsigned valid_cycles = 0, stab_viol = 0, done_cnt = 0;
  logic [31:0] p_addr = '0, p_data = '0;
  logic [3:0]  p_strb = '0;
  bit          p_pend = 1'b0;

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (mem_valid) begin
      valid_cycles++;
      if (p_pend && (mem_addr !== p_addr || mem_wdata !== p_data || mem_wstrb !== p_strb))
        stab_viol++;
    end
    if (mem_valid && mem_ready) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_wdata);
      q_strb.push_back(mem_wstrb);
    end
    p_pend = mem_valid && !mem_ready;
    p_addr = mem_addr;
    p_data = mem_wdata;
    p_strb = mem_wstrb;
  end

  // ---------------- reference model ----------------
  logic [31:0] e_addr[$];
  logic [31:0] e_data[$];
  logic [3:0]  e_strb[$];

  // A copy is len read/write pairs over word-aligned, wrapping address ranges
  task automatic build_expect(input logic [31:0] s, input logic [31:0] d, input int l);
    logic [31:0] sa, da;
    e_addr.delete(); e_data.delete(); e_strb.delete();
    sa = s & ~32'd3;
    da = d & ~32'd3;
    for (int i = 0; i < l; i++) begin
      e_addr.push_back(sa + 32'(4 * i)); e_strb.push_back(4'h0); e_data.push_back('0);
      e_addr.push_back(da + 32'(4 * i)); e_strb.push_back(4'hF);
      e_data.push_back(mem_word(sa + 32'(4 * i)));
    end
  endtask

  // Cycles from the start cycle to done: 2+waits per bus phase, two gaps, one FIN
  function automatic int exp_latency(input int l, input int rw, input int ww);
    if (l == 0) return 1;
    return 1 + l * (6 + rw + ww);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start, optionally poke start/inputs mid-copy, wait (bounded) for done,
  // then step into IDLE so the caller may start again immediately
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l,
                          input int glitch_at, output int lat, output bit got);
    src = s; dst = d; len = LEN_W'(l); start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; got = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (done) begin lat = k; got = 1'b1; break; end
      if (k == glitch_at) begin
        start = 1'b1; src = $urandom; dst = $urandom; len = LEN_W'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({busy, done, error, words_done, mem_valid, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b valid=%b addr=%h wdata=%h, required all 0",
                         busy, mem_valid, mem_addr, mem_wdata);
    end
    rstn = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({busy, done, error, mem_valid} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b error=%b valid=%b, required 0",
                         busy, done, error, mem_valid);
    end
  endtask

  task automatic test_single_word();
    int lat; bit got; int b;
    rd_waits = 0; wr_waits = 0;
    mem[32'h0] = 32'h2001_0737;
    build_expect(32'h0, 32'h0010_0000, 1);
    b = q_addr.size();
    run_copy(32'h0, 32'h0010_0000, 1, 0, lat, got);
    n_tests++;
    if (!got || lat != 7) begin
      n_fail++; $display("FAIL single_latency: got %0d (done seen=%0d), required 7", lat, got);
    end
    n_tests++;
    if (words_done !== 16'd1 || error !== 1'b0) begin
      n_fail++; $display("FAIL single_status: got words_done=%0d error=%b, required 1/0", words_done, error);
    end
    n_tests++;
    if (q_addr.size() - b != 2) begin
      n_fail++; $display("FAIL single_txn_count: got %0d, required 2", q_addr.size() - b);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (q_addr[b+i] !== e_addr[i] || q_strb[b+i] !== e_strb[i] ||
            (e_strb[i] == 4'hF && q_data[b+i] !== e_data[i])) begin
          n_fail++; $display("FAIL single_txn%0d: got addr=%h strb=%h data=%h, required addr=%h strb=%h data=%h",
                             i, q_addr[b+i], q_strb[b+i], q_data[b+i], e_addr[i], e_strb[i], e_data[i]);
        end
      end
    end
  endtask

  task automatic test_burst_unaligned();
    int lat; bit got; int b;
    for (int i = 0; i < 4; i++) mem[32'(4 * i)] = 32'hA000_0000 + 32'(i * 17);
    build_expect(32'h3, 32'h0010_0100, 4);
    b = q_addr.size();
    run_copy(32'h3, 32'h0010_0100, 4, 0, lat, got);
    n_tests++;
    if (!got || lat != exp_latency(4, 0, 0)) begin
      n_fail++; $display("FAIL burst_latency: got %0d, required %0d", lat, exp_latency(4, 0, 0));
    end
    n_tests++;
    if (q_addr.size() - b != 8) begin
      n_fail++; $display("FAIL burst_txn_count: got %0d, required 8", q_addr.size() - b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (q_addr[b+i] !== e_addr[i] || q_strb[b+i] !== e_strb[i] ||
            (e_strb[i] == 4'hF && q_data[b+i] !== e_data[i])) begin
          n_fail++; $display("FAIL burst_txn%0d: got addr=%h strb=%h data=%h, required addr=%h strb=%h data=%h",
                             i, q_addr[b+i], q_strb[b+i], q_data[b+i], e_addr[i], e_strb[i], e_data[i]);
        end
      end
    end
    n_tests++;
    if (words_done !== 16'd4 || stab_viol != 0) begin
      n_fail++; $display("FAIL burst_status: got words_done=%0d stability_violations=%0d, required 4/0",
                         words_done, stab_viol);
    end
  endtask

  task automatic test_zero_len();
    int unsigned v0;
    v0 = valid_cycles;
    src = 32'h100; dst = 32'h200; len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      n_fail++; $display("FAIL zero_fin: got busy=%b done=%b, required 1/1", busy, done);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || words_done !== '0 || valid_cycles != v0) begin
      n_fail++; $display("FAIL zero_after: got busy=%b done=%b words_done=%0d valid_cycles=%0d, required 0/0/0/0",
                         busy, done, words_done, valid_cycles - v0);
    end
  endtask

  task automatic test_timeout();
    int lat; bit got; int b; int unsigned v0;
    no_ready = 1'b1;
    v0 = valid_cycles;
    b = q_addr.size();
    run_copy(32'h40, 32'h200, 3, 0, lat, got);
    n_tests++;
    if (!got || lat != TIMEOUT + 1) begin
      n_fail++; $display("FAIL timeout_latency: got %0d (done seen=%0d), required %0d", lat, got, TIMEOUT + 1);
    end
    n_tests++;
    if (valid_cycles - v0 != TIMEOUT || q_addr.size() != b) begin
      n_fail++; $display("FAIL timeout_valid_cycles: got %0d txns=%0d, required %0d/0",
                         valid_cycles - v0, q_addr.size() - b, TIMEOUT);
    end
    n_tests++;
    if (error !== 1'b1 || words_done !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_status: got error=%b words_done=%0d busy=%b, required 1/0/0",
                         error, words_done, busy);
    end
    no_ready = 1'b0;
    src = 32'h40; dst = 32'h200; len = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_error_clear: got error=%b busy=%b, required 0/1", error, busy);
    end
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (done) got = 1'b1;
      tick();
    end
    n_tests++;
    if (!got || words_done !== 16'd1 || error !== 1'b0) begin
      n_fail++; $display("FAIL timeout_recover: got done=%0d words_done=%0d error=%b, required 1/1/0",
                         got, words_done, error);
    end
  endtask

  task automatic test_wait_wrap();
    int lat; bit got; int b;
    rd_waits = 2; wr_waits = 0;
    mem[32'h80] = 32'h1111_2222;
    mem[32'h84] = 32'h3333_4444;
    build_expect(32'h80, 32'hFFFF_FFFC, 2);
    b = q_addr.size();
    run_copy(32'h80, 32'hFFFF_FFFC, 2, 0, lat, got);
    n_tests++;
    if (!got || lat != 17) begin
      n_fail++; $display("FAIL wait_latency: got %0d, required 17", lat);
    end
    n_tests++;
    if (q_addr.size() - b != 4 || q_addr[b+1] !== 32'hFFFF_FFFC || q_addr[b+3] !== 32'h0 ||
        q_data[b+3] !== 32'h3333_4444) begin
      n_fail++; $display("FAIL wrap_writes: got %0d txns, second write addr=%h data=%h, required 4/00000000/33334444",
                         q_addr.size() - b, q_addr[b+3], q_data[b+3]);
    end
    rd_waits = 0;
  endtask

  task automatic test_reset_mid_copy();
    bit found; int unsigned d0; int lat; bit got;
    rd_waits = 0; wr_waits = 0;
    found = 1'b0;
    src = 32'h500; dst = 32'h600; len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (words_done == 16'd1 && mem_valid && mem_wstrb == 4'hF) found = 1'b1;
      else tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL midreset_reach_wr2: got no WR of word 2, required one");
    end
    d0 = done_cnt;
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, error, words_done, mem_valid, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got busy=%b valid=%b words_done=%0d addr=%h, required all 0",
                         busy, mem_valid, words_done, mem_addr);
    end
    tick();
    rstn = 1'b1;
    repeat (10) tick();
    n_tests++;
    if (done_cnt != d0 || busy !== 1'b0 || mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: got done pulses=%0d busy=%b valid=%b, required 0/0/0",
                         done_cnt - d0, busy, mem_valid);
    end
    run_copy(32'h500, 32'h600, 1, 0, lat, got);
    n_tests++;
    if (!got || lat != 7) begin
      n_fail++; $display("FAIL midreset_restart: got latency %0d, required 7", lat);
    end
  endtask

  task automatic test_ignored_start();
    int lat; bit got; int b;
    mem[32'h300] = 32'hDEAD_0001;
    mem[32'h304] = 32'hDEAD_0002;
    build_expect(32'h300, 32'h400, 2);
    b = q_addr.size();
    run_copy(32'h300, 32'h400, 2, 3, lat, got);
    n_tests++;
    if (!got || lat != 13 || words_done !== 16'd2) begin
      n_fail++; $display("FAIL ignored_start_latency: got %0d words_done=%0d, required 13/2", lat, words_done);
    end
    n_tests++;
    if (q_addr.size() - b != 4) begin
      n_fail++; $display("FAIL ignored_start_txns: got %0d, required 4", q_addr.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (q_addr[b+i] !== e_addr[i] || q_strb[b+i] !== e_strb[i] ||
            (e_strb[i] == 4'hF && q_data[b+i] !== e_data[i])) begin
          n_fail++; $display("FAIL ignored_start_txn%0d: got addr=%h data=%h, required addr=%h data=%h",
                             i, q_addr[b+i], q_data[b+i], e_addr[i], e_data[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat; bit got; int b; int l; logic [31:0] s, d;
    for (int it = 0; it < 8; it++) begin
      s = 32'h1000_0000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      d = 32'h2000_0000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      l = $urandom_range(1, 5);
      rd_waits = $urandom_range(0, 3);
      wr_waits = $urandom_range(0, 3);
      for (int i = 0; i < l; i++) mem[(s & ~32'd3) + 32'(4 * i)] = $urandom;
      build_expect(s, d, l);
      b = q_addr.size();
      run_copy(s, d, l, 0, lat, got);
      n_tests++;
      if (!got || lat != exp_latency(l, rd_waits, wr_waits) || words_done !== LEN_W'(l) || error !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_status: got lat=%0d words_done=%0d error=%b, required %0d/%0d/0",
                           it, lat, words_done, error, exp_latency(l, rd_waits, wr_waits), l);
      end
      n_tests++;
      if (q_addr.size() - b != 2 * l) begin
        n_fail++; $display("FAIL rand%0d_txn_count: got %0d, required %0d", it, q_addr.size() - b, 2 * l);
      end else begin
        for (int i = 0; i < 2 * l; i++) begin
          if (q_addr[b+i] !== e_addr[i] || q_strb[b+i] !== e_strb[i] ||
              (e_strb[i] == 4'hF && q_data[b+i] !== e_data[i])) begin
            n_fail++; $display("FAIL rand%0d_txn%0d: got addr=%h strb=%h data=%h, required addr=%h strb=%h data=%h",
                               it, i, q_addr[b+i], q_strb[b+i], q_data[b+i], e_addr[i], e_strb[i], e_data[i]);
            break;
          end
        end
      end
    end
    n_tests++;
    if (stab_viol != 0) begin
      n_fail++; $display("FAIL bus_stability: got %0d violations, required 0", stab_viol);
    end
    rd_waits = 0; wr_waits = 0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst_unaligned();
    test_zero_len();
    test_timeout();
    test_wait_wrap();
    test_reset_mid_copy();
    test_ignored_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_copy_master.md
# mem_copy_master

Word-copy engine acting as an initiator on the PicoRV32 native memory bus. It reads `len` 32-bit words starting at `src` and writes them to consecutive words starting at `dst`. The bus targets are registered-ready responders such as the program ROM, the data RAM and the QSPI window. It serves as the boot-time loader that moves firmware from flash or ROM into RAM before the CPU is released, and it is also usable as a simple DMA.

## Interface
- `TIMEOUT`, default 256: cycles `mem_valid` may wait without `mem_ready` before the copy aborts; must be ≥ 2.
- `LEN_W`, default 16: width of the length and word counters.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only while `busy`=0.
- `src` in 32: source byte address; bits [1:0] ignored, forced to 0.
- `dst` in 32: destination byte address; bits [1:0] ignored, forced to 0.
- `len` in LEN_W: number of words to copy.
- `busy` out 1: copy in progress.
- `done` out 1: one-cycle pulse when a copy ends, whether it completed or aborted.
- `error` out 1: set on timeout; sticky until the next accepted `start`.
- `words_done` out LEN_W: count of words fully written in the current or last copy.
- `mem_valid` out 1: bus request.
- `mem_addr` out 32: bus word address.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: byte strobes; 4'b0000 for reads, 4'b1111 for writes.
- `mem_ready` in 1: responder acknowledge.
- `mem_rdata` in 32: read data, valid while `mem_ready`=1.

## Operation
- **Reset values:** all outputs 0; state IDLE; internal address and counter registers 0.
- **States:** IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- **IDLE:**
  - `start`=1 and `len`≠0: latch `src`, `dst` and `len`; clear `error` and `words_done`; go to RD.
  - `start`=1 and `len`=0: clear `error` and `words_done`; go to FIN with no bus traffic.
- **RD:**
  - Drive `mem_valid`=1, `mem_addr`=current src, `mem_wstrb`=0.
  - On `mem_ready`, capture `mem_rdata` into `mem_wdata` and go to RD_GAP.
- **RD_GAP:** `mem_valid`=0 for exactly one cycle; go to WR.
- **WR:**
  - Drive `mem_valid`=1, `mem_addr`=current dst, `mem_wstrb`=4'hF, `mem_wdata` held.
  - On `mem_ready`, increment `words_done`, add 4 to src and dst, decrement the remaining count, and go to WR_GAP.
- **WR_GAP:** `mem_valid`=0 for one cycle. Go to FIN if the remaining count is 0, otherwise go to RD.
- **FIN:** `done`=1 for one cycle; go to IDLE.
- **Bus rules:**
  - `mem_addr`, `mem_wdata` and `mem_wstrb` are stable for the whole time `mem_valid` is high.
  - `mem_valid` never drops before `mem_ready` except on timeout.
- **Gap states:** ignore `mem_ready`. A registered-ready responder repeats `ready` for one cycle after `valid` falls, and that repeat must not be counted as a new acknowledge.
- **Timeout:**
  - A counter clears on entry to RD or WR and increments each cycle there with `mem_ready`=0.
  - When it reaches `TIMEOUT`, drop `mem_valid`, set `error`=1, and go to FIN.
  - `words_done` holds the number of words completed before the abort.
- **Arithmetic:** src and dst wrap modulo 2^32; the remaining count is LEN_W bits, so `len`=2^LEN_W−1 is the maximum.
- **Ignored inputs:** `start` while `busy`=1 is ignored, and `src`, `dst` and `len` changes during a copy have no effect.
- **Reset mid-copy:** returns immediately to IDLE with all outputs 0. The bus transaction is abandoned and no `done` is issued.

## Timing
- `busy`=1 from the cycle after `start` is accepted through the FIN cycle inclusive; it is 0 in IDLE.
- `start` is accepted again on the cycle `busy` returns to 0.
- With a responder that asserts `ready` one cycle after `valid` (zero wait states):
  - RD = 2 cycles, RD_GAP = 1, WR = 2, WR_GAP = 1, so each word takes 6 cycles.
  - `done` comes 6·len + 1 cycles after the `start` cycle.
- `len`=0: `done` one cycle after `start`.
- Each wait state the responder inserts adds exactly one cycle to RD or WR.
- `mem_wdata` is registered and changes only on an RD acknowledge.

## Structure
- **Shared package `mem_bus_pkg`:**
  - state enum `copy_state_t`;
  - `WSTRB_READ`=4'h0 and `WSTRB_WORD`=4'hF;
  - `WORD_BYTES`=4.
- **Sub-module `bus_timeout`:** parameterised by `TIMEOUT`, inputs `clr` and `tick`, output `expired`. The same counter is reused by the CPU-side bus watchdog.
- Everything else is a single FSM with its datapath registers.

## Test plan
1. **Single word:** ROM model holds word[0]=32'h20010737; copy `src`=0, `dst`=0x0010_0000, `len`=1.
   - Exactly one read at 0 and one write at 0x0010_0000 with wdata 32'h20010737 and wstrb F.
   - `done` at cycle 7 after `start`; `words_done`=1; `error`=0.
2. **Burst with unaligned `src`:** `len`=4, `src`=0x0000_0003.
   - Reads occur at 0, 4, 8, 0xC; writes go to dst..dst+0xC in order.
   - `done` at 25 cycles; no extra transaction is caused by the repeated `ready` in gap cycles.
3. **Zero length:** `len`=0.
   - No `mem_valid` ever asserted; `done` on the next cycle; `busy` high for 1 cycle.
4. **Timeout:** responder never asserts `ready`, `TIMEOUT`=8, `len`=3.
   - `mem_valid` drops after 8 waiting cycles; `error`=1; `done` pulses; `words_done`=0.
   - The next `start` clears `error`.
5. **Wait states and wrap:**
   - Responder inserts 2 wait states, `len`=2: `done` at 6·2+1+4=17 cycles.
   - `dst`=0xFFFF_FFFC: the second write goes to 0x0000_0000.
6. **Reset and ignored start:**
   - `rstn` pulsed low during the WR of word 2: outputs go to 0 immediately, no `done`, IDLE afterwards.
   - `start` pulsed while `busy`=1 has no effect.
